// File: rtl/pipe_addsub.sv
// Carry-pipelined adder/subtractor: CHUNK bits are summed per stage, and the
// unsummed operand bits ride along in skew registers with their bundle.
module pipe_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_c;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic              r_ovf;
  logic              r_zero;

  logic              w_stall;
  logic              w_cin0;
  logic [STAGES-1:0] w_v_in;
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_c_out;
  logic [WIDTH-1:0]  w_a_in  [STAGES];
  logic [WIDTH-1:0]  w_b_in  [STAGES];
  logic [WIDTH-1:0]  w_s_in  [STAGES];
  logic [WIDTH-1:0]  w_s_out [STAGES];
  logic [CHUNK:0]    w_part  [STAGES];
  logic              w_msb_cin;
  logic              w_ovf;
  logic              w_zero;

  // The whole chain freezes together, so bubbles keep their slots.
  assign w_stall  = (r_v[LAST] & ~out_ready) | ~ena;
  assign in_ready = ~w_stall;

  // NOTE: every combinational output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    case (op)
      2'b00:   w_cin0 = 1'b0;
      2'b01:   w_cin0 = 1'b1;
      2'b10:   w_cin0 = cin;
      default: w_cin0 = ~cin;
    endcase
  end

  always_comb begin
    w_v_in[0] = in_valid;
    w_c_in[0] = w_cin0;
    w_a_in[0] = a;
    w_b_in[0] = op[0] ? ~b : b;
    w_s_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_v_in[k] = r_v[k-1];
      w_c_in[k] = r_c[k-1];
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_s_in[k] = r_s[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_part[k] = {1'b0, w_a_in[k][k*CHUNK +: CHUNK]}
                + {1'b0, w_b_in[k][k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, w_c_in[k]};
      w_s_out[k] = w_s_in[k];
      w_s_out[k][k*CHUNK +: CHUNK] = w_part[k][CHUNK-1:0];
      w_c_out[k] = w_part[k][CHUNK];
    end
    // Carry into the MSB recovered from the MSB sum bit and its operand bits.
    w_msb_cin = w_s_out[LAST][WIDTH-1] ^ w_a_in[LAST][WIDTH-1] ^ w_b_in[LAST][WIDTH-1];
    w_ovf     = w_msb_cin ^ w_c_out[LAST];
    w_zero    = (w_s_out[LAST] == '0);
  end

  // NOTE: pipeline state is cleared in reset so no stale bundle survives it; non-blocking only here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v    <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else if (!w_stall) begin
      r_v    <= w_v_in;
      r_c    <= w_c_out;
      r_ovf  <= w_ovf;
      r_zero <= w_zero;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= w_a_in[k];
        r_b[k] <= w_b_in[k];
        r_s[k] <= w_s_out[k];
      end
    end
  end

  assign out_valid = r_v[LAST];
  assign sum       = r_s[LAST];
  assign cout      = r_c[LAST];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub (WIDTH=8, CHUNK=4): scoreboard of hand-computed
// results plus explicit latency, back-pressure, enable and reset checks.
module tb_pipe_addsub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] op;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       zero;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pop    = 0;

  logic [10:0] r_exp;          // {cout, ovf, zero, sum} of the bundle being driven
  logic [10:0] exp_q [$];

  pipe_addsub #(.WIDTH(8), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change at posedge+1, so the negedge sees exactly what the next edge uses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready && ena) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(sum), 32'hFFFF_FFFF);
        end else begin
          check("result", 32'({cout, ovf, zero, sum}), 32'(exp_q.pop_front()));
          n_pop++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(r_exp);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the acceptance edge.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [1:0] top,
                      input logic tcin, input logic [10:0] texp);
    int waited = 0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    op       = top;
    cin      = tcin;
    r_exp    = texp;
    do begin
      @(negedge clk);
      waited++;
    end while (!in_ready && waited < 50);
    if (!in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] held_sum;
  logic       held_v;
  int         pops_before;

  initial begin
    rst_n     = 1'b0;
    ena       = 1'b1;
    in_valid  = 1'b1;
    a         = 8'h55;
    b         = 8'h55;
    op        = 2'b00;
    cin       = 1'b0;
    out_ready = 1'b1;
    r_exp     = '0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flags", 32'({cout, ovf, zero, sum}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("rst_no_accept", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
    check("idle_after_rst", 32'(out_valid), 32'd0);

    // Latency: accept at edge t, result visible right after edge t+1.
    send(8'hF0, 8'h10, 2'b00, 1'b0, {1'b1, 1'b0, 1'b1, 8'h00});
    check("lat_not_early", 32'(out_valid), 32'd0);
    step();
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_result", 32'({cout, ovf, zero, sum}), 32'({1'b1, 1'b0, 1'b1, 8'h00}));
    step();
    check("bubble", 32'(out_valid), 32'd0);

    // Back-to-back stream of directed vectors.
    send(8'h7F, 8'h01, 2'b00, 1'b0, {1'b0, 1'b1, 1'b0, 8'h80});
    send(8'h80, 8'h01, 2'b01, 1'b0, {1'b1, 1'b1, 1'b0, 8'h7F});
    send(8'h0F, 8'h00, 2'b10, 1'b1, {1'b0, 1'b0, 1'b0, 8'h10});
    send(8'h00, 8'h00, 2'b11, 1'b1, {1'b0, 1'b0, 1'b0, 8'hFF});
    send(8'h05, 8'h05, 2'b01, 1'b0, {1'b1, 1'b0, 1'b1, 8'h00});
    send(8'h12, 8'h34, 2'b10, 1'b0, {1'b0, 1'b0, 1'b0, 8'h46});
    send(8'h50, 8'h20, 2'b11, 1'b0, {1'b1, 1'b0, 1'b0, 8'h30});
    send(8'h01, 8'h01, 2'b00, 1'b1, {1'b0, 1'b0, 1'b0, 8'h02});
    send(8'h03, 8'h01, 2'b01, 1'b1, {1'b1, 1'b0, 1'b0, 8'h02});
    repeat (4) step();
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    check("stream_count", 32'(n_pop), 32'd10);

    // Back-pressure: only STAGES bundles fit while the consumer stalls.
    out_ready   = 1'b0;
    pops_before = n_pop;
    fork
      begin
        send(8'h11, 8'h22, 2'b00, 1'b0, {1'b0, 1'b0, 1'b0, 8'h33});
        send(8'h44, 8'h55, 2'b00, 1'b0, {1'b0, 1'b1, 1'b0, 8'h99});
        send(8'hFF, 8'hFF, 2'b00, 1'b0, {1'b1, 1'b0, 1'b0, 8'hFE});
        send(8'h80, 8'h80, 2'b00, 1'b0, {1'b1, 1'b1, 1'b1, 8'h00});
      end
      begin
        repeat (2) step();
        check("bp_full", 32'(in_ready), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        repeat (3) step();
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_sum_held", 32'(sum), 32'h33);
        check("bp_accepted", 32'(exp_q.size()), 32'd2);
        out_ready = 1'b1;
      end
    join
    repeat (4) step();
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_count", 32'(n_pop - pops_before), 32'd4);

    // Enable low freezes everything mid-stream.
    pops_before = n_pop;
    fork
      begin
        send(8'h01, 8'h02, 2'b00, 1'b0, {1'b0, 1'b0, 1'b0, 8'h03});
        send(8'h10, 8'h01, 2'b01, 1'b0, {1'b1, 1'b0, 1'b0, 8'h0F});
        send(8'hAA, 8'h55, 2'b00, 1'b0, {1'b0, 1'b0, 1'b0, 8'hFF});
        send(8'hC0, 8'h40, 2'b10, 1'b1, {1'b1, 1'b0, 1'b0, 8'h01});
      end
      begin
        repeat (2) step();
        ena      = 1'b0;
        #1;
        held_sum = sum;
        held_v   = out_valid;
        check("ena_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
          step();
          check("ena_sum_frozen", 32'(sum), 32'(held_sum));
          check("ena_valid_frozen", 32'(out_valid), 32'(held_v));
        end
        ena = 1'b1;
      end
    join
    repeat (4) step();
    check("ena_drained", 32'(exp_q.size()), 32'd0);
    check("ena_count", 32'(n_pop - pops_before), 32'd4);

    // Reset with two bundles in flight discards both.
    out_ready = 1'b0;
    send(8'h21, 8'h01, 2'b00, 1'b0, {1'b0, 1'b0, 1'b0, 8'h22});
    send(8'h31, 8'h01, 2'b00, 1'b0, {1'b0, 1'b0, 1'b0, 8'h32});
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    out_ready = 1'b1;
    step();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, meaning operand and result width in bits (>=2).
REQ-002 The block SHALL provide parameter CHUNK, default 4, meaning bits summed per pipeline stage; WIDTH SHALL be a multiple of CHUNK; STAGES = WIDTH/CHUNK.
REQ-003 The block SHALL provide port clk, input, 1 bit: the only clock, rising-edge active.
REQ-004 The block SHALL provide port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL provide port ena, input, 1 bit: global enable; low freezes all state.
REQ-006 The block SHALL provide port in_valid, input, 1 bit: operand bundle present.
REQ-007 The block SHALL provide port in_ready, output, 1 bit: block can accept a bundle this cycle.
REQ-008 The block SHALL provide ports a and b, input, WIDTH bits each: operands.
REQ-009 The block SHALL provide port op, input, 2 bits: 00 add, 01 sub (a-b), 10 add with cin, 11 sub with borrow (a-b-cin).
REQ-010 The block SHALL provide port cin, input, 1 bit: carry/borrow-in, used only for op 10/11.
REQ-011 The block SHALL provide port out_valid, output, 1 bit: result present.
REQ-012 The block SHALL provide port out_ready, input, 1 bit: consumer accepts result this cycle.
REQ-013 The block SHALL provide port sum, output, WIDTH bits: result modulo 2^WIDTH.
REQ-014 The block SHALL provide ports cout, ovf and zero, output, 1 bit each: unsigned carry-out (for sub: 1 = no borrow), two's-complement signed overflow, and sum==0.

Function
REQ-015 Effective carry-in SHALL be 0 for op 00, 1 for op 01, cin for op 10, and ~cin for op 11; subtract ops SHALL use ~b as the second operand.
REQ-016 The adder SHALL be a carry-pipelined chain of STAGES registered stages; stage k sums bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1.
REQ-017 Operand bits not yet summed SHALL travel with their bundle through skew registers, so results are never mixed between bundles.
REQ-018 A bundle SHALL be accepted on a rising edge where in_valid & in_ready & ena is high.
REQ-019 Latency: the result SHALL appear on sum/flags with out_valid=1 immediately after the STAGES-th rising edge, counting the acceptance edge as the first, provided no stall occurs.
REQ-020 A stall SHALL be defined as (out_valid & ~out_ready) | ~ena; during a stall every pipeline register and valid bit SHALL hold.
REQ-021 in_ready SHALL equal ~stall (combinational); with no stall the block SHALL sustain one bundle per cycle.
REQ-022 Bubbles (in_valid=0) SHALL propagate as valid=0 stage entries; bubbles SHALL NOT be squeezed out during stalls.
REQ-023 sum, cout, ovf and zero SHALL be registered in the final stage and remain stable while out_valid=1 and out_ready=0.
REQ-024 ovf SHALL be 1 when the MSB carry-in differs from the MSB carry-out of the final stage.
REQ-025 With out_ready=0 held indefinitely, at most STAGES bundles SHALL be held in flight, and no bundle SHALL be lost or duplicated.
REQ-026 in_valid and the operand inputs SHALL be ignored on edges where in_ready=0.

Reset
REQ-027 rst_n low SHALL asynchronously clear all stage valid bits, carries and data registers; out_valid, sum, cout, ovf and zero SHALL read 0 while reset is asserted.
REQ-028 in_ready SHALL be 1 during reset, but no bundle SHALL be accepted until the first rising edge after rst_n deasserts.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight bundles, with no partial result emitted afterwards.

Verification (WIDTH=8, CHUNK=4, STAGES=2)
REQ-030 Add: a=0xF0, b=0x10, op=00, accepted at edge t -> after edge t+1: sum=0x00, cout=1, ovf=0, zero=1, out_valid=1.
REQ-031 Signed overflow: a=0x7F, b=0x01, op=00 -> sum=0x80, cout=0, ovf=1, zero=0; sub a=0x80, b=0x01, op=01 -> sum=0x7F, cout=1, ovf=1.
REQ-032 Carry and borrow in: a=0x0F, b=0x00, op=10, cin=1 -> sum=0x10 (chunk carry crosses stage); op=11, a=0x00, b=0x00, cin=1 -> sum=0xFF, cout=0.
REQ-033 Back-pressure: stream 4 bundles with out_ready=0 -> in_ready drops to 0 after 2 accepted, sum held stable; raise out_ready -> remaining results appear in order, one per cycle, none lost or duplicated.
REQ-034 ena and reset: drop ena for 3 cycles mid-stream -> outputs and in_ready=0 frozen, then the stream resumes unchanged; assert rst_n=0 with 2 bundles in flight -> out_valid=0 immediately, and no stale result appears after release.
